// File: rtl/rr_request_encoder.sv
// Round-robin request encoder: buffers request pulses on N lines and emits them
// one at a time as an encoded address under a ready/valid handshake.
module rr_request_encoder #(
    parameter int N  = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          ready,
    output logic [AW-1:0] address,
    output logic          valid,
    output logic [N-1:0]  sel,
    output logic          busy
);

    logic [N-1:0]  pending;
    logic [N-1:0]  pend_eff;
    logic [AW-1:0] ptr;
    logic [AW-1:0] grant;
    logic [AW-1:0] idx;
    logic          found;
    logic          accept;
    logic          load;

    assign accept = valid & ready;
    assign load   = (~valid | accept) & found;

    // A fresh request on the line being accepted keeps its bit set.
    always_comb begin
        pend_eff = pending | req;
        if (accept && !req[address])
            pend_eff[address] = 1'b0;
    end

    // Search starts at ptr; AW-bit arithmetic wraps N-1 back to 0.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = ptr + AW'(i);
            if (!found && pend_eff[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
            ptr     <= '0;
            address <= '0;
            valid   <= 1'b0;
        end else if (load) begin
            address <= grant;
            valid   <= 1'b1;
            ptr     <= grant + AW'(1);
            pending <= pend_eff & ~(N'(1) << grant);
        end else begin
            pending <= pend_eff;
            if (accept)
                valid <= 1'b0;
        end
    end

    always_comb begin
        sel = '0;
        if (valid)
            sel[address] = 1'b1;
    end

    assign busy = (|pending) | valid;

endmodule

// File: tb/tb_rr_request_encoder.sv
// Directed table-driven bench for rr_request_encoder (N=8): each record is
// applied for one clock and the registered outputs are compared after the edge.
module tb_rr_request_encoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] req = 8'h00;
    logic       ready = 1'b0;
    logic [2:0] address;
    logic       valid;
    logic [7:0] sel;
    logic       busy;

    int total = 0;
    int bad   = 0;

    rr_request_encoder #(.N(8), .AW(3)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .ready   (ready),
        .address (address),
        .valid   (valid),
        .sel     (sel),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       rdy;
        logic       v;
        logic [2:0] a;
        logic [7:0] s;
        logic       b;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic [7:0] rq, input logic rdy,
                                input logic v, input logic [2:0] a, input logic b);
        vec_t t;
        t.rst = rst; t.req = rq; t.rdy = rdy;
        t.v = v; t.a = a; t.b = b;
        t.s = v ? (8'd1 << a) : 8'd0;
        vecs.push_back(t);
    endfunction

    task automatic cmp(input string name, input int step, input logic [7:0] got, input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s step %0d: got %0h want %0h", name, step, got, want);
        end
    endtask

    task automatic apply(input vec_t t, input int step);
        @(negedge clk);
        reset = t.rst;
        req   = t.req;
        ready = t.rdy;
        @(posedge clk);
        #1;
        cmp("valid",   step, {7'd0, valid}, {7'd0, t.v});
        cmp("address", step, {5'd0, address}, {5'd0, t.a});
        cmp("sel",     step, sel, t.s);
        cmp("busy",    step, {7'd0, busy}, {7'd0, t.b});
    endtask

    initial begin
        // reset with all requests asserted: they must be ignored
        add(1, 8'hFF, 0, 0, 0, 0);
        add(1, 8'hFF, 0, 0, 0, 0);
        add(0, 8'h00, 1, 0, 0, 0);
        // single pulse on line 5
        add(0, 8'h20, 1, 1, 5, 1);
        add(0, 8'h00, 1, 0, 5, 0);
        // round robin from ptr=0, twice
        add(1, 8'h00, 1, 0, 0, 0);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 8; i++)
                add(0, (i == 0) ? 8'hFF : 8'h00, 1, 1, 3'(i), 1);
            add(0, 8'h00, 1, 0, 7, 0);
        end
        // stall: line 0 held four cycles, then line 3
        add(0, 8'h09, 0, 1, 0, 1);
        add(0, 8'h00, 0, 1, 0, 1);
        add(0, 8'h00, 0, 1, 0, 1);
        add(0, 8'h00, 0, 1, 0, 1);
        add(0, 8'h00, 1, 1, 3, 1);
        add(0, 8'h00, 1, 0, 3, 0);
        // fairness: lines 1 and 6 held, ptr=4
        add(0, 8'h42, 1, 1, 6, 1);
        add(0, 8'h42, 1, 1, 1, 1);
        add(0, 8'h42, 1, 1, 6, 1);
        add(0, 8'h42, 1, 1, 1, 1);
        add(0, 8'h00, 1, 1, 6, 1);
        add(0, 8'h00, 1, 0, 6, 0);
        // re-request of line 2 in its accept cycle, ptr=7
        add(0, 8'h04, 1, 1, 2, 1);
        add(0, 8'h14, 1, 1, 4, 1);
        add(0, 8'h00, 1, 1, 2, 1);
        add(0, 8'h00, 1, 0, 2, 0);
        // reset in the middle of a five-line burst, ptr=3
        add(0, 8'h1F, 1, 1, 3, 1);
        add(0, 8'h00, 1, 1, 4, 1);
        add(1, 8'hFF, 1, 0, 0, 0);
        add(0, 8'h00, 1, 0, 0, 0);
        add(0, 8'h00, 1, 0, 0, 0);

        foreach (vecs[k])
            apply(vecs[k], k);

        // repeated request on the line held in the stalled output collapses to one grant
        begin
            vec_t t;
            t.rst = 0; t.req = 8'h01; t.rdy = 0; t.v = 1; t.a = 0; t.s = 8'h01; t.b = 1;
            apply(t, 100);
            apply(t, 101);
            t.req = 8'h00; t.rdy = 1; t.v = 0; t.s = 8'h00; t.b = 0;
            apply(t, 102);
            apply(t, 103);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
